ep_rx_packet_ctrl: RTL and testbench

- Receive-side sequencer for the endpoint data path.
- Collects a 96-bit packet one byte at a time, validates the header token and the CRC16, and presents the 72-bit payload downstream with a valid/ready handshake.
- Tracks inter-byte timeouts and keeps a saturating count of CRC errors.
- Reuses the existing CRC16_D72 combinational core, with a zero seed, for the CRC check.

---
 rtl/ep_rx_packet_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ep_rx_packet_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ep_rx_packet_ctrl.sv
// Receive-side packet sequencer: collects a 12-byte packet, checks header and CRC16,
// and hands the 72-bit payload downstream over a valid/ready handshake.
module ep_rx_packet_ctrl #(
    parameter logic [7:0] HDR_TOKEN = 8'h3C,
    parameter int         TIMEOUT   = 16,
    parameter int         ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic [71:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                crc_err,
    output logic                hdr_err,
    output logic                tmo_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int          GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [15:0] CRC_POLY = 16'h8005;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHECK   = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    // CRC16_D72 core: 72 data bits folded MSB-first into the running remainder.
    function automatic logic [15:0] crc16_d72(input logic [71:0] data, input logic [15:0] crc);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 71; i >= 0; i--) begin
            fb = data[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    state_t              state_r, state_s;
    logic [95:0]         pkt_r;
    logic [3:0]          byte_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [71:0]         out_data_r;
    logic                out_valid_r;
    logic                crc_err_r, hdr_err_r, tmo_err_r;
    logic [ERRCNT_W-1:0] err_count_r;

    logic                hdr_ok_s, crc_ok_s, timeout_s;
    logic [6:0]          wr_lsb_s;

    assign hdr_ok_s  = (in_byte == HDR_TOKEN);
    assign crc_ok_s  = (crc16_d72(pkt_r[87:16], 16'h0000) == pkt_r[15:0]);
    // The byte wins: a timeout only fires on a cycle with no in_valid.
    assign timeout_s = (state_r == S_COLLECT) && !in_valid && (gap_cnt_r == GAP_W'(TIMEOUT - 1));
    assign wr_lsb_s  = 7'd88 - {byte_cnt_r, 3'b000};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid && hdr_ok_s) begin
                    state_s = S_COLLECT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (in_valid && (byte_cnt_r == 4'd11)) begin
                    state_s = S_CHECK;
                end else if (timeout_s) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_COLLECT;
                end
            end
            S_CHECK: begin
                if (crc_ok_s) begin
                    state_s = S_OUT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_OUT: begin
                if (out_valid_r && out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Packet assembly, gap timing, payload output and error reporting.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            pkt_r       <= 96'd0;
            byte_cnt_r  <= 4'd0;
            gap_cnt_r   <= {GAP_W{1'b0}};
            out_data_r  <= 72'd0;
            out_valid_r <= 1'b0;
            crc_err_r   <= 1'b0;
            hdr_err_r   <= 1'b0;
            tmo_err_r   <= 1'b0;
            err_count_r <= {ERRCNT_W{1'b0}};
        end else begin
            crc_err_r <= 1'b0;
            hdr_err_r <= 1'b0;
            tmo_err_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (in_valid && hdr_ok_s) begin
                        pkt_r[95:88] <= in_byte;
                        byte_cnt_r   <= 4'd1;
                        gap_cnt_r    <= {GAP_W{1'b0}};
                    end else if (in_valid) begin
                        hdr_err_r <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        pkt_r[wr_lsb_s +: 8] <= in_byte;
                        byte_cnt_r           <= byte_cnt_r + 4'd1;
                        gap_cnt_r            <= {GAP_W{1'b0}};
                    end else if (timeout_s) begin
                        tmo_err_r  <= 1'b1;
                        pkt_r      <= 96'd0;
                        byte_cnt_r <= 4'd0;
                        gap_cnt_r  <= {GAP_W{1'b0}};
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                S_CHECK: begin
                    if (crc_ok_s) begin
                        out_data_r  <= pkt_r[87:16];
                        out_valid_r <= 1'b1;
                    end else begin
                        crc_err_r <= 1'b1;
                        if (err_count_r != {ERRCNT_W{1'b1}}) begin
                            err_count_r <= err_count_r + ERRCNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_valid_r && out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = (state_r != S_IDLE);
    assign crc_err   = crc_err_r;
    assign hdr_err   = hdr_err_r;
    assign tmo_err   = tmo_err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_ep_rx_packet_ctrl.sv
// Scoreboard bench for ep_rx_packet_ctrl: stimulus pushes expected events, a negedge
// monitor pops them as the DUT reports payloads or error pulses.
module tb_ep_rx_packet_ctrl;

    localparam int EW = 2;
    localparam int K_OUT = 0, K_CRC = 1, K_HDR = 2, K_TMO = 3;

    logic          clk = 1'b0;
    logic          reset_L;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic [71:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy, crc_err, hdr_err, tmo_err;
    logic [EW-1:0] err_count;

    typedef struct {
        int          kind;
        logic [71:0] data;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ep_rx_packet_ctrl #(.HDR_TOKEN(8'h3C), .TIMEOUT(16), .ERRCNT_W(EW)) dut (
        .clk(clk), .reset_L(reset_L), .in_byte(in_byte), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .crc_err(crc_err), .hdr_err(hdr_err), .tmo_err(tmo_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference CRC: remainder of payload * x^16 divided by x^16+x^15+x^2+1.
    function automatic logic [15:0] crc_ref(input logic [71:0] d);
        logic [87:0] r;
        r = {d, 16'h0000};
        for (int i = 87; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ 17'h18005;
        end
        return r[15:0];
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [71:0] data, input int cnt);
        exp_t e;
        e.kind = kind; e.data = data; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_range(input logic [95:0] w, input int first, input int last);
        for (int n = first; n <= last; n++) send_byte(w[95 - 8*n -: 8]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_data"}, out_data, 72'd0);
        chk({tag, "_outs"}, {67'd0, out_valid, busy, crc_err, hdr_err, tmo_err}, 72'd0);
        chk({tag, "_err_count"}, 72'(err_count), 72'd0);
    endtask

    // Monitor: every reported event must match the head of the scoreboard.
    always @(negedge clk) begin
        int   nev;
        int   kind;
        exp_t e;
        nev  = int'(out_valid && out_ready) + int'(crc_err) + int'(hdr_err) + int'(tmo_err);
        kind = (out_valid && out_ready) ? K_OUT : crc_err ? K_CRC : hdr_err ? K_HDR : K_TMO;
        if (nev > 1) chk("mon_exclusive", 72'(nev), 72'd1);
        if (nev > 0) begin
            if (q.size() == 0) begin
                chk("mon_unexpected_event", 72'(kind), 72'hFF);
            end else begin
                e = q.pop_front();
                chk("mon_kind", 72'(kind), 72'(e.kind));
                if (e.kind == K_OUT && kind == K_OUT) chk("mon_out_data", out_data, e.data);
                if (e.kind == K_CRC && kind == K_CRC) chk("mon_err_count", 72'(err_count), 72'(e.cnt));
            end
        end
    end

    initial begin
        logic [71:0] p1, p2;
        logic [15:0] c1, c2;
        logic [95:0] w1, w1_bad, w2;
        p1 = 72'h010203040506070809;
        p2 = 72'hA55AFF00123456789A;
        c1 = crc_ref(p1);
        c2 = crc_ref(p2);
        w1     = {8'h3C, p1, c1};
        w1_bad = {8'h3C, p1, c1 ^ 16'h0001};
        w2     = {8'h3C, p2, c2};

        reset_L = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
        step(); step();
        check_all_zero("reset");
        reset_L = 1'b1;
        step();

        // Good packet, back-to-back, out_ready high.
        push(K_OUT, p1, 0);
        send_range(w1, 0, 11);
        chk("good_check_cycle_valid", 72'(out_valid), 72'd0);
        chk("good_check_cycle_busy", 72'(busy), 72'd1);
        step();
        chk("good_latency_valid", 72'(out_valid), 72'd1);
        chk("good_data", out_data, 72'h010203040506070809);
        step();
        chk("good_release_valid", 72'(out_valid), 72'd0);
        chk("good_release_busy", 72'(busy), 72'd0);

        // Bad CRC.
        push(K_CRC, 72'd0, 1);
        send_range(w1_bad, 0, 11);
        step();
        chk("bad_valid", 72'(out_valid), 72'd0);
        chk("bad_busy", 72'(busy), 72'd0);
        chk("bad_err_count", 72'(err_count), 72'd1);

        // Header reject, then back-pressure for 5 cycles.
        push(K_HDR, 72'd0, 0);
        send_byte(8'h3D);
        chk("hdr_busy", 72'(busy), 72'd0);
        step();
        out_ready = 1'b0;
        push(K_OUT, p2, 0);
        send_range(w2, 0, 11);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", 72'(out_valid), 72'd1);
            chk("bp_hold_data", out_data, p2);
            if (i < 4) step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 72'(out_valid), 72'd0);
        chk("bp_release_busy", 72'(busy), 72'd0);

        // Timeout after header plus 4 bytes.
        push(K_TMO, 72'd0, 0);
        send_range(w1, 0, 4);
        repeat (15) step();
        chk("tmo_not_yet", 72'(tmo_err), 72'd0);
        chk("tmo_busy_before", 72'(busy), 72'd1);
        step();
        chk("tmo_pulse", 72'(tmo_err), 72'd1);
        chk("tmo_busy_after", 72'(busy), 72'd0);
        step();

        // Byte arriving on gap cycle 16 continues the packet.
        push(K_OUT, p1, 0);
        send_range(w1, 0, 4);
        repeat (15) step();
        send_range(w1, 5, 11);
        step();
        chk("gap16_valid", 72'(out_valid), 72'd1);
        step();
        chk("gap16_busy", 72'(busy), 72'd0);

        // Fresh counter, then saturation of a 2-bit error count.
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
        chk("sat_start", 72'(err_count), 72'd0);
        for (int k = 1; k <= 5; k++) begin
            push(K_CRC, 72'd0, (k > 3) ? 3 : k);
            send_range(w1_bad, 0, 11);
            step();
            chk("sat_count", 72'(err_count), 72'((k > 3) ? 3 : k));
        end

        // Reset mid-packet.
        send_range(w1, 0, 3);
        reset_L = 1'b0;
        step();
        check_all_zero("rst_mid");
        reset_L = 1'b1;
        step();

        // Reset while a payload is pending.
        out_ready = 1'b0;
        send_range(w2, 0, 11);
        step();
        chk("rst_pend_valid_before", 72'(out_valid), 72'd1);
        reset_L = 1'b0;
        step();
        check_all_zero("rst_pend");
        reset_L = 1'b1;
        out_ready = 1'b1;
        step();

        // Good packet after reset.
        push(K_OUT, p1, 0);
        send_range(w1, 0, 11);
        step();
        chk("post_rst_data", out_data, p1);
        step();
        step();
        chk("scoreboard_drained", 72'(q.size()), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
